fetch_decode_queue: RTL and testbench
=====================================

Name: fetch_decode_queue

Overview:
- Instruction queue between the fetch stage and decode; replaces a plain IF/ID register.
- Decouples fetch from decode stalls.
- Buffers {pc, pcPlus4, instr, err} tuples in program order.
- Backpressures fetch through its stall input.
- Drops all buffered instructions on a branch, jump or interrupt redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- XLEN, 32, address and instruction width.
- NOP_INSTR, 32'h00000013, instruction presented on instr_ID when the queue is empty (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- fetch_valid  input  1  fetch is presenting a valid instruction this cycle.
- pc_IF  input  XLEN  PC of the presented instruction.
- pcPlus4_IF  input  XLEN  pc_IF+4 as computed by fetch.
- instr_IF  input  XLEN  instruction word.
- err_IF  input  1  fetch error (misaligned or illegal address) for this instruction.
- stall_IF  output  1  queue full; drives the fetch stall input.
- flush  input  1  redirect (taken branch, jump or interrupt); discards all entries.
- stall_ID  input  1  decode cannot accept the head entry this cycle.
- valid_ID  output  1  head entry valid.
- pc_ID  output  XLEN  head PC.
- pcPlus4_ID  output  XLEN  head PC+4.
- instr_ID  output  XLEN  head instruction, or NOP_INSTR when empty.
- err_ID  output  1  head error flag; 0 when empty.
- occupancy  output  $clog2(DEPTH+1)  current entry count.

Behaviour:
- Reset (rst high at an edge):
  - Pointers and count go to 0; valid_ID=0.
  - instr_ID=NOP_INSTR; pc_ID=0, pcPlus4_ID=0, err_ID=0.
  - stall_IF=0, occupancy=0.
  - rst has priority over every other input. Reset mid-stream discards all entries.
- Definitions:
  - full = (count==DEPTH); empty = (count==0).
  - stall_IF = full. It is derived from registered count only, with no combinational path from stall_ID or fetch_valid.
  - push = fetch_valid && !full && !flush.
  - pop = !empty && !stall_ID && !flush.
- Storage and pointers:
  - Circular buffer with wr_ptr and rd_ptr, each $clog2(DEPTH) bits.
  - Pointers wrap naturally from DEPTH-1 to 0.
  - count is tracked separately.
- Latency and output path:
  - An entry pushed at edge N is visible on the *_ID outputs in the cycle after edge N. No same-cycle bypass from fetch to decode.
  - The *_ID outputs are driven from the head entry (show-ahead).
  - valid_ID = !empty.
  - When empty, the outputs take the empty values listed under reset.
- Count update:
  - push without pop: count+1.
  - pop without push: count-1.
  - push and pop together: count unchanged, both pointers advance.
  - At full with pop: no push that cycle, since stall_IF was already high. count goes to DEPTH-1, and stall_IF deasserts next cycle.
- Fetch contract: while stall_IF=1, fetch holds pc_IF, instr_IF and related inputs. The queue never overwrites; push is gated by full.
- Flush:
  - At the edge, count, wr_ptr and rd_ptr clear to 0.
  - Any same-cycle push and pop are ignored.
  - valid_ID=0 and instr_ID=NOP_INSTR in the next cycle.
  - The first post-redirect instruction is accepted the cycle after flush.
- Decode stall:
  - While stall_ID=1 the head entry and all *_ID outputs stay stable.
  - The queue keeps filling until full.
- Errors: an entry with err_IF=1 is queued and ordered like any other, and is reported via err_ID when at the head. No sticky state.
- The stored pcPlus4 is the value from fetch; it is not recomputed.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - typedef fd_entry_t: packed struct {pc, pcPlus4, instr, err}.
  - constant NOP_INSTR.
  - typedef for the occupancy width.
- One natural sub-module, fd_queue_mem: DEPTH x fd_entry_t register array with one write port and one asynchronous read port, plus the write enable.
- Pointer, count and flush control remain in fetch_decode_queue.

Test Plan:
1. Reset, then push pc 0x0, 0x4, 0x8 with stall_ID=0 -> each appears on pc_ID one cycle after its push; valid_ID=1 for three consecutive cycles; occupancy never exceeds 1.
2. Hold stall_ID=1 and push 5 instructions with DEPTH=4 -> stall_IF=1 after the 4th push; occupancy=4; pc_ID stays 0x0; the 5th instruction is held by fetch and not lost.
3. From full, release stall_ID for one cycle -> pop of 0x0; next cycle pc_ID=0x4, occupancy=3, stall_IF=0. The held 5th instruction is pushed next, exercising wrap of wr_ptr from 3 to 0.
4. Queue holds 3 entries; assert flush together with fetch_valid (pc 0x100) and stall_ID=0 -> next cycle valid_ID=0, instr_ID=0x00000013, occupancy=0. Pc 0x100 is not queued; a push the following cycle appears as pc_ID=0x100.
5. Push an entry with err_IF=1 at pc 0x2 behind two good entries -> err_ID=1 only when pc_ID=0x2 is at the head; 0 otherwise.
6. Assert rst for one cycle while the queue holds 2 entries and push and pop are both active -> next cycle all outputs are at reset values and occupancy=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the fetch/decode boundary: queue entry layout,
// the empty-slot NOP and the default occupancy width.
package pipeline_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned QUEUE_DEPTH = 4;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [$clog2(QUEUE_DEPTH+1)-1:0] occ_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlus4;
    logic [XLEN-1:0] instr;
    logic            err;
  } fd_entry_t;

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch-side and decode-side handshake bundle of the fetch/decode queue.
interface fetch_decode_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
);

  logic                         fetch_valid;
  logic [XLEN-1:0]              pc_IF;
  logic [XLEN-1:0]              pcPlus4_IF;
  logic [XLEN-1:0]              instr_IF;
  logic                         err_IF;
  logic                         stall_IF;
  logic                         flush;
  logic                         stall_ID;
  logic                         valid_ID;
  logic [XLEN-1:0]              pc_ID;
  logic [XLEN-1:0]              pcPlus4_ID;
  logic [XLEN-1:0]              instr_ID;
  logic                         err_ID;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;

  // Pipeline side: fetch, decode and redirect logic.
  modport master (
    output fetch_valid, pc_IF, pcPlus4_IF, instr_IF, err_IF, flush, stall_ID,
    input  stall_IF, valid_ID, pc_ID, pcPlus4_ID, instr_ID, err_ID, occupancy
  );

  // Queue side.
  modport slave (
    input  fetch_valid, pc_IF, pcPlus4_IF, instr_IF, err_IF, flush, stall_ID,
    output stall_IF, valid_ID, pc_ID, pcPlus4_ID, instr_ID, err_ID, occupancy
  );

endinterface

// File: rtl/fd_queue_mem.sv
// Entry storage for the fetch/decode queue: one synchronous write port and
// one asynchronous read port. Contents are not reset; validity lives in the count.
module fd_queue_mem
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  fd_entry_t                wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output fd_entry_t                rdata_o
);

  fd_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_decode_queue.sv
// Show-ahead instruction queue between fetch and decode. Backpressures fetch
// when full and drops everything on a redirect.
module fetch_decode_queue
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input logic                clk,
  input logic                rst,
  fetch_decode_queue_if.slave q
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic      full, empty, push, pop;
  fd_entry_t wr_entry, head;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = q.fetch_valid && !full && !q.flush;
  assign pop   = !empty && !q.stall_ID && !q.flush;

  assign wr_entry = '{
    pc:      q.pc_IF,
    pcPlus4: q.pcPlus4_IF,
    instr:   q.instr_IF,
    err:     q.err_IF
  };

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: pointers wrap by overflow.
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fd_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // Stale storage is masked so decode sees a clean bubble when empty.
  assign q.stall_IF   = full;
  assign q.valid_ID   = !empty;
  assign q.pc_ID      = empty ? '0 : head.pc;
  assign q.pcPlus4_ID = empty ? '0 : head.pcPlus4;
  assign q.instr_ID   = empty ? NOP_INSTR : head.instr;
  assign q.err_ID     = empty ? 1'b0 : head.err;
  assign q.occupancy  = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue with a queue-based reference model
// compared against the decode-side outputs after every clock edge.
module tb_fetch_decode_queue;
  import pipeline_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  fd_entry_t exp_q[$];

  fetch_decode_queue_if #(.DEPTH(DEPTH), .XLEN(32)) bus ();

  fetch_decode_queue #(
    .DEPTH (DEPTH),
    .XLEN  (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic drive(input logic fv, input logic [31:0] pc, input logic err,
                       input logic sid, input logic fl);
    bus.fetch_valid = fv;
    bus.pc_IF       = pc;
    bus.pcPlus4_IF  = pc + 32'd4;
    bus.instr_IF    = 32'hA000_0000 | pc;
    bus.err_IF      = err;
    bus.stall_ID    = sid;
    bus.flush       = fl;
  endtask

  task automatic compare_all();
    fd_entry_t h;
    if (exp_q.size() == 0) begin
      check("valid_ID", 32'(bus.valid_ID), 32'd0);
      check("pc_ID", bus.pc_ID, 32'd0);
      check("pcPlus4_ID", bus.pcPlus4_ID, 32'd0);
      check("instr_ID", bus.instr_ID, NOP_INSTR);
      check("err_ID", 32'(bus.err_ID), 32'd0);
    end else begin
      h = exp_q[0];
      check("valid_ID", 32'(bus.valid_ID), 32'd1);
      check("pc_ID", bus.pc_ID, h.pc);
      check("pcPlus4_ID", bus.pcPlus4_ID, h.pcPlus4);
      check("instr_ID", bus.instr_ID, h.instr);
      check("err_ID", 32'(bus.err_ID), 32'(h.err));
    end
    check("occupancy", 32'(bus.occupancy), 32'(exp_q.size()));
    check("stall_IF", 32'(bus.stall_IF), 32'(exp_q.size() == DEPTH));
  endtask

  // One clock: model decides push/pop from pre-edge state, then outputs are compared.
  task automatic tick();
    bit        m_push, m_pop;
    fd_entry_t e;
    m_push = bus.fetch_valid && (exp_q.size() < DEPTH) && !bus.flush;
    m_pop  = (exp_q.size() != 0) && !bus.stall_ID && !bus.flush;
    e = '{pc: bus.pc_IF, pcPlus4: bus.pcPlus4_IF, instr: bus.instr_IF, err: bus.err_IF};
    @(posedge clk);
    if (rst || bus.flush) begin
      exp_q.delete();
    end else begin
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(e);
    end
    #1;
    compare_all();
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset state
    tick();
    check("reset_instr_nop", bus.instr_ID, 32'h0000_0013);
    rst = 1'b0;

    // 1: flow-through, one-cycle latency, occupancy stays at 1
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0);
      tick();
      check("t1_pc_ID", bus.pc_ID, 32'(i * 4));
      check("t1_occ_le1", 32'(bus.occupancy <= 1), 32'd1);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();

    // 2: decode stalled, fill to full, fifth instruction held by fetch
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 1'b1, 1'b0);
      tick();
    end
    check("t2_stall_IF", 32'(bus.stall_IF), 32'd1);
    check("t2_occ_full", 32'(bus.occupancy), 32'd4);
    drive(1'b1, 32'h10, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    check("t2_pc_ID_held", bus.pc_ID, 32'h0);

    // 3: single pop from full, then held instruction enters with wr_ptr wrap
    drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    tick();
    check("t3_pc_ID", bus.pc_ID, 32'h4);
    check("t3_occ", 32'(bus.occupancy), 32'd3);
    check("t3_stall_IF", 32'(bus.stall_IF), 32'd0);
    drive(1'b1, 32'h10, 1'b0, 1'b1, 1'b0);
    tick();
    check("t3_occ_refill", 32'(bus.occupancy), 32'd4);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();

    // 4: flush with coincident push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(32'h20 + i * 4), 1'b0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
    tick();
    check("t4_valid_ID", 32'(bus.valid_ID), 32'd0);
    check("t4_instr_nop", bus.instr_ID, 32'h0000_0013);
    check("t4_occ", 32'(bus.occupancy), 32'd0);
    drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    tick();
    check("t4_pc_ID_redirect", bus.pc_ID, 32'h100);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();

    // 5: errored entry behind two good ones
    drive(1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h44, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h2, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("t5_err_at_head", 32'(bus.err_ID), 32'(bus.valid_ID && bus.pc_ID == 32'h2));
      tick();
    end

    // 6: reset mid-stream with push and pop active
    drive(1'b1, 32'h50, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h54, 1'b0, 1'b1, 1'b0);
    tick();
    check("t6_occ_before", 32'(bus.occupancy), 32'd2);
    rst = 1'b1;
    drive(1'b1, 32'h58, 1'b0, 1'b0, 1'b0);
    tick();
    check("t6_occ_reset", 32'(bus.occupancy), 32'd0);
    check("t6_valid_reset", 32'(bus.valid_ID), 32'd0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
